// File: rtl/yapay_zeka_carp_topla_if.sv
// Operand/result bundle between the weight/data register banks and the MAC stage.
//   ddb_durdur_i   : pipeline stall, freezes every stage
//   carpma_rst_i   : high clears and idles; low marks the operand pair valid
//   carp_deger1_i  : data operand (signed)
//   carp_deger2_i  : weight operand (signed)
//   sonuc_o        : accumulator value
//   sonuc_gecerli_o: BOYUT products accumulated, held until cleared
//   adet_o         : number of products accumulated so far
interface yapay_zeka_carp_topla_if #(
    parameter int unsigned VERI_BIT = 32,
    parameter int unsigned ADET_BIT = 5
);
    logic                ddb_durdur_i;
    logic                carpma_rst_i;
    logic [VERI_BIT-1:0] carp_deger1_i;
    logic [VERI_BIT-1:0] carp_deger2_i;
    logic [VERI_BIT-1:0] sonuc_o;
    logic                sonuc_gecerli_o;
    logic [ADET_BIT-1:0] adet_o;

    // Producer side: register banks / instruction control
    modport master (
        output ddb_durdur_i, carpma_rst_i, carp_deger1_i, carp_deger2_i,
        input  sonuc_o, sonuc_gecerli_o, adet_o
    );

    // MAC stage side
    modport slave (
        input  ddb_durdur_i, carpma_rst_i, carp_deger1_i, carp_deger2_i,
        output sonuc_o, sonuc_gecerli_o, adet_o
    );
endinterface

// File: rtl/yapay_zeka_carp_topla.sv
// Three-stage multiply-accumulate for the convolution unit: latch operand pair,
// form the low VERI_BIT bits of the product, add into a wrapping accumulator.
// Completes after BOYUT products; further pairs are dropped until cleared.
//   clk_i : clock, rising edge
//   rst_ni: asynchronous active-low reset
//   bus   : operand inputs, stall/clear controls and result outputs
module yapay_zeka_carp_topla #(
    parameter int unsigned VERI_BIT = 32,
    parameter int unsigned BOYUT    = 16,
    parameter int unsigned ADET_BIT = 5
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    yapay_zeka_carp_topla_if.slave   bus
);
    localparam logic [ADET_BIT-1:0] ADET_SON    = ADET_BIT'(BOYUT);
    localparam logic [ADET_BIT-1:0] ADET_SON_M1 = ADET_BIT'(BOYUT - 1);

    typedef enum logic [1:0] {
        BOS   = 2'b00,
        TOPLA = 2'b01,
        BITTI = 2'b10
    } durum_t;

    durum_t              durum_q, durum_d;
    logic [ADET_BIT-1:0] kabul_q;
    logic                a_gecerli_q, b_gecerli_q;
    logic [VERI_BIT-1:0] deger1_q, deger2_q;
    logic [VERI_BIT-1:0] carpim_q;
    logic [VERI_BIT-1:0] toplam_q;
    logic [ADET_BIT-1:0] adet_q;
    logic                kabul_c;
    logic                son_c;
    logic                gecerli_c;

    // Pair is taken only when not cleared, not stalled and quota not reached
    assign kabul_c = !bus.carpma_rst_i && !bus.ddb_durdur_i && (kabul_q < ADET_SON);
    // The accumulation that brings adet to BOYUT happens on this edge
    assign son_c   = b_gecerli_q && (adet_q == ADET_SON_M1);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) durum_q <= BOS;
        else         durum_q <= durum_d;
    end

    // Next-state logic
    always_comb begin
        durum_d = durum_q;
        if (bus.carpma_rst_i) begin
            durum_d = BOS;
        end else if (!bus.ddb_durdur_i) begin
            case (durum_q)
                BOS:     if (kabul_c) durum_d = TOPLA;
                TOPLA:   if (son_c)   durum_d = BITTI;
                BITTI:   durum_d = BITTI;
                default: durum_d = BOS;
            endcase
        end
    end

    // Output decode: done is a level tied to the BITTI state flop
    always_comb begin
        gecerli_c = 1'b0;
        if (durum_q == BITTI) gecerli_c = 1'b1;
    end

    // Pipeline datapath
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            kabul_q     <= '0;
            a_gecerli_q <= 1'b0;
            b_gecerli_q <= 1'b0;
            deger1_q    <= '0;
            deger2_q    <= '0;
            carpim_q    <= '0;
            toplam_q    <= '0;
            adet_q      <= '0;
        end else if (bus.carpma_rst_i) begin
            // In-flight products are discarded with their valids
            kabul_q     <= '0;
            a_gecerli_q <= 1'b0;
            b_gecerli_q <= 1'b0;
            toplam_q    <= '0;
            adet_q      <= '0;
        end else if (!bus.ddb_durdur_i) begin
            a_gecerli_q <= kabul_c;
            if (kabul_c) begin
                deger1_q <= bus.carp_deger1_i;
                deger2_q <= bus.carp_deger2_i;
                kabul_q  <= kabul_q + ADET_BIT'(1);
            end
            b_gecerli_q <= a_gecerli_q;
            // Low half of the product is sign-agnostic
            if (a_gecerli_q) carpim_q <= deger1_q * deger2_q;
            if (b_gecerli_q) begin
                toplam_q <= toplam_q + carpim_q;
                adet_q   <= adet_q + ADET_BIT'(1);
            end
        end
    end

    assign bus.sonuc_o         = toplam_q;
    assign bus.adet_o          = adet_q;
    assign bus.sonuc_gecerli_o = gecerli_c;
endmodule

// File: tb/tb_yapay_zeka_carp_topla.sv
// Directed bench for the convolution multiply-accumulate stage.
module tb_yapay_zeka_carp_topla;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    yapay_zeka_carp_topla_if #(.VERI_BIT(32), .ADET_BIT(5)) bus ();

    yapay_zeka_carp_topla #(.VERI_BIT(32), .BOYUT(16), .ADET_BIT(5)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; outputs are then sampled 1 time unit later
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One edge of clear, leaving the block idle (carpma_rst_i stays high)
    task automatic temizle;
        bus.ddb_durdur_i  = 1'b0;
        bus.carpma_rst_i  = 1'b1;
        bus.carp_deger1_i = '0;
        bus.carp_deger2_i = '0;
        tick();
    endtask

    // Present the same pair on n consecutive edges
    task automatic cift_sur(input logic [31:0] a, input logic [31:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            bus.carpma_rst_i  = 1'b0;
            bus.carp_deger1_i = a;
            bus.carp_deger2_i = b;
            tick();
        end
    endtask

    // Wait for completion, bounded; n is the number of edges waited
    task automatic bitis_bekle(input int limit, output int n);
        n = 0;
        while (!bus.sonuc_gecerli_o && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset;
        rst_n             = 1'b0;
        bus.ddb_durdur_i  = 1'b0;
        bus.carpma_rst_i  = 1'b1;
        bus.carp_deger1_i = '0;
        bus.carp_deger2_i = '0;
        tick();
        tick();
        checks++;
        if (bus.sonuc_o !== 32'h0 || bus.adet_o !== 5'd0 || bus.sonuc_gecerli_o !== 1'b0) begin
            errors++;
            $display("FAIL reset: sonuc=%h adet=%0d gecerli=%b, expected 0/0/0",
                     bus.sonuc_o, bus.adet_o, bus.sonuc_gecerli_o);
        end
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        temizle();
        cift_sur(32'd3, 32'hFFFF_FFFE, 16);
        checks++;
        if (bus.sonuc_o !== 32'hFFFF_FFAC || bus.adet_o !== 5'd14) begin
            errors++;
            $display("FAIL basic_edge16: sonuc=%h adet=%0d, expected ffffffac/14", bus.sonuc_o, bus.adet_o);
        end
        tick();
        checks++;
        if (bus.sonuc_o !== 32'hFFFF_FFA6 || bus.adet_o !== 5'd15 || bus.sonuc_gecerli_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_edge17: sonuc=%h adet=%0d gecerli=%b, expected ffffffa6/15/0",
                     bus.sonuc_o, bus.adet_o, bus.sonuc_gecerli_o);
        end
        tick();
        checks++;
        if (bus.sonuc_o !== 32'hFFFF_FFA0 || bus.adet_o !== 5'd16 || bus.sonuc_gecerli_o !== 1'b1) begin
            errors++;
            $display("FAIL basic_edge18: sonuc=%h adet=%0d gecerli=%b, expected ffffffa0/16/1",
                     bus.sonuc_o, bus.adet_o, bus.sonuc_gecerli_o);
        end
        // Pairs still presented after completion must be dropped
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.sonuc_o !== 32'hFFFF_FFA0 || bus.sonuc_gecerli_o !== 1'b1) begin
                errors++;
                $display("FAIL basic_hold%0d: sonuc=%h gecerli=%b, expected ffffffa0/1",
                         i, bus.sonuc_o, bus.sonuc_gecerli_o);
            end
        end
        bus.carpma_rst_i = 1'b1;
        tick();
        checks++;
        if (bus.sonuc_o !== 32'h0 || bus.adet_o !== 5'd0 || bus.sonuc_gecerli_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_clear: sonuc=%h adet=%0d gecerli=%b, expected 0/0/0",
                     bus.sonuc_o, bus.adet_o, bus.sonuc_gecerli_o);
        end
    endtask

    task automatic test_overflow;
        int n;
        temizle();
        cift_sur(32'h4000_0000, 32'd2, 3);
        checks++;
        if (bus.sonuc_o !== 32'h8000_0000 || bus.adet_o !== 5'd1) begin
            errors++;
            $display("FAIL overflow_first: sonuc=%h adet=%0d, expected 80000000/1", bus.sonuc_o, bus.adet_o);
        end
        tick();
        checks++;
        if (bus.sonuc_o !== 32'h0 || bus.adet_o !== 5'd2) begin
            errors++;
            $display("FAIL overflow_wrap: sonuc=%h adet=%0d, expected 0/2", bus.sonuc_o, bus.adet_o);
        end
        cift_sur(32'h4000_0000, 32'd2, 12);
        bitis_bekle(10, n);
        checks++;
        if (bus.sonuc_gecerli_o !== 1'b1 || bus.sonuc_o !== 32'h0 || bus.adet_o !== 5'd16) begin
            errors++;
            $display("FAIL overflow_final: gecerli=%b sonuc=%h adet=%0d, expected 1/0/16",
                     bus.sonuc_gecerli_o, bus.sonuc_o, bus.adet_o);
        end
    endtask

    task automatic test_stall;
        int e;
        int n;
        e = 0;
        temizle();
        for (int k = 1; k <= 5; k++) begin
            cift_sur(32'd1, 32'(k), 1);
            e++;
        end
        checks++;
        if (bus.sonuc_o !== 32'd6 || bus.adet_o !== 5'd3) begin
            errors++;
            $display("FAIL stall_pre: sonuc=%0d adet=%0d, expected 6/3", bus.sonuc_o, bus.adet_o);
        end
        bus.ddb_durdur_i  = 1'b1;
        bus.carp_deger2_i = 32'd6;
        for (int i = 0; i < 3; i++) begin
            tick();
            e++;
            checks++;
            if (bus.sonuc_o !== 32'd6 || bus.adet_o !== 5'd3 || bus.sonuc_gecerli_o !== 1'b0) begin
                errors++;
                $display("FAIL stall_frozen%0d: sonuc=%0d adet=%0d, expected 6/3", i, bus.sonuc_o, bus.adet_o);
            end
        end
        bus.ddb_durdur_i = 1'b0;
        for (int k = 6; k <= 16; k++) begin
            cift_sur(32'd1, 32'(k), 1);
            e++;
        end
        bitis_bekle(10, n);
        e += n;
        checks++;
        if (bus.sonuc_gecerli_o !== 1'b1 || bus.sonuc_o !== 32'd136 || e != 21) begin
            errors++;
            $display("FAIL stall_final: gecerli=%b sonuc=%0d done_edge=%0d, expected 1/136/21",
                     bus.sonuc_gecerli_o, bus.sonuc_o, e);
        end
    endtask

    task automatic test_mid_clear;
        int n;
        temizle();
        cift_sur(32'd5, 32'd5, 8);
        checks++;
        if (bus.sonuc_o !== 32'd150 || bus.adet_o !== 5'd6) begin
            errors++;
            $display("FAIL clear_pre: sonuc=%0d adet=%0d, expected 150/6", bus.sonuc_o, bus.adet_o);
        end
        bus.carpma_rst_i = 1'b1;
        tick();
        checks++;
        if (bus.sonuc_o !== 32'd0 || bus.adet_o !== 5'd0 || bus.sonuc_gecerli_o !== 1'b0) begin
            errors++;
            $display("FAIL clear_edge: sonuc=%0d adet=%0d gecerli=%b, expected 0/0/0",
                     bus.sonuc_o, bus.adet_o, bus.sonuc_gecerli_o);
        end
        cift_sur(32'd1, 32'd1, 16);
        bitis_bekle(10, n);
        checks++;
        if (bus.sonuc_gecerli_o !== 1'b1 || bus.sonuc_o !== 32'd16 || bus.adet_o !== 5'd16) begin
            errors++;
            $display("FAIL clear_final: gecerli=%b sonuc=%0d adet=%0d, expected 1/16/16",
                     bus.sonuc_gecerli_o, bus.sonuc_o, bus.adet_o);
        end
    endtask

    task automatic test_excess;
        temizle();
        cift_sur(32'd2, 32'd2, 20);
        checks++;
        if (bus.sonuc_o !== 32'd64 || bus.adet_o !== 5'd16 || bus.sonuc_gecerli_o !== 1'b1) begin
            errors++;
            $display("FAIL excess_final: sonuc=%0d adet=%0d gecerli=%b, expected 64/16/1",
                     bus.sonuc_o, bus.adet_o, bus.sonuc_gecerli_o);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus.sonuc_o !== 32'd64 || bus.adet_o !== 5'd16) begin
                errors++;
                $display("FAIL excess_hold%0d: sonuc=%0d adet=%0d, expected 64/16", i, bus.sonuc_o, bus.adet_o);
            end
        end
    endtask

    task automatic test_async_reset;
        int n;
        temizle();
        cift_sur(32'd1, 32'h10, 5);
        checks++;
        if (bus.sonuc_o !== 32'h30) begin
            errors++;
            $display("FAIL async_pre: sonuc=%h, expected 30", bus.sonuc_o);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.sonuc_o !== 32'h0 || bus.adet_o !== 5'd0 || bus.sonuc_gecerli_o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: sonuc=%h adet=%0d gecerli=%b, expected 0/0/0",
                     bus.sonuc_o, bus.adet_o, bus.sonuc_gecerli_o);
        end
        bus.carpma_rst_i = 1'b1;
        #2 rst_n = 1'b1;
        tick();
        cift_sur(32'd1, 32'd1, 16);
        bitis_bekle(10, n);
        checks++;
        if (bus.sonuc_gecerli_o !== 1'b1 || bus.sonuc_o !== 32'd16) begin
            errors++;
            $display("FAIL async_rerun: gecerli=%b sonuc=%0d, expected 1/16",
                     bus.sonuc_gecerli_o, bus.sonuc_o);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_overflow();
        test_stall();
        test_mid_clear();
        test_excess();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/yapay_zeka_carp_topla.md
Name: yapay_zeka_carp_topla

Overview:
- Multiply-accumulate stage directly downstream of the AI accelerator's weight/data register banks.
- Consumes one data/weight operand pair per cycle while the multiply-reset line is low.
- Multiplies each pair in a pipeline and accumulates BOYUT products into a 32-bit convolution result, which the X-instruction writeback path reads.
- Flags completion once the pipeline has drained.

Parameters:
- VERI_BIT, 32, operand and accumulator width.
- BOYUT, 16, number of products per convolution; operand pairs beyond this are ignored.
- ADET_BIT, 5, width of the product counter; must satisfy 2^ADET_BIT > BOYUT.

Ports:
- clk_i  input  1  clock, all state on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- ddb_durdur_i  input  1  pipeline stall; freezes every stage.
- carpma_rst_i  input  1  high: clear and idle. Low: operand pair on carp_deger*_i is valid this cycle.
- carp_deger1_i  input  VERI_BIT  data operand (signed).
- carp_deger2_i  input  VERI_BIT  weight operand (signed).
- sonuc_o  output  VERI_BIT  accumulator value.
- sonuc_gecerli_o  output  1  high once BOYUT products are accumulated; held until cleared.
- adet_o  output  ADET_BIT  number of products accumulated so far.

Behaviour:
- Reset (rst_ni=0, asynchronous, immediate):
  - sonuc_o=0, sonuc_gecerli_o=0, adet_o=0.
  - Stage valids=0, accepted-count=0, FSM=BOS.
- Priority at each edge: rst_ni > carpma_rst_i > ddb_durdur_i > normal operation.
- carpma_rst_i=1 (synchronous): at the next edge clear the accumulator, adet, accepted-count and all stage valids, and set FSM=BOS. This happens even when stalled.
- ddb_durdur_i=1 with carpma_rst_i=0: no register changes, no operand accepted, outputs hold.
- Pipeline: 3 register stages, no backpressure other than the stall.
  - Stage A: on an edge with carpma_rst_i=0, no stall, and accepted-count<BOYUT, latch both operands, set A-valid, and increment accepted-count. Otherwise clear A-valid.
  - Stage B: if A-valid, the product register gets the low VERI_BIT bits of carp_deger1×carp_deger2. The low half is identical for signed and unsigned operands. B-valid follows A-valid.
  - Stage C: if B-valid, accumulator += product modulo 2^VERI_BIT (wrap, no saturation), and adet increments.
- Latency: a pair accepted at edge N contributes to sonuc_o after edge N+2.
- FSM states:
  - BOS: idle.
  - TOPLA: accumulating.
  - BITTI: done.
- FSM transitions:
  - BOS→TOPLA when the first pair is accepted.
  - TOPLA→BITTI at the edge where adet becomes BOYUT. sonuc_gecerli_o rises at that same edge.
  - BITTI holds, and sonuc_o is frozen, until carpma_rst_i=1 returns the FSM to BOS.
- Operand pairs presented while accepted-count==BOYUT, or in BITTI, are dropped without effect.
- A stall in TOPLA freezes all in-flight products; they resume without loss or duplication.
- carpma_rst_i asserted mid-run: all in-flight products are discarded, nothing partial is accumulated, and the next run starts from 0.
- sonuc_gecerli_o is a level, not a pulse, and is never high with adet_o≠BOYUT.

Test Plan:
- Release reset, hold carpma_rst_i=0, and drive 16 pairs (3, 0xFFFFFFFE) on consecutive edges 1..16 -> adet_o=16 and sonuc_o=0xFFFFFFA0 (-96) after edge 18. sonuc_gecerli_o rises at edge 18 and stays high until carpma_rst_i=1.
- Overflow: 16 pairs (0x40000000, 2), each product 0x80000000 -> sonuc_o wraps to 0x00000000 after 16 products, sonuc_gecerli_o=1.
- Stall: pairs (1, k) for k=1..16 with ddb_durdur_i=1 for 3 cycles after the 5th pair -> sonuc_o frozen during the stall, final sonuc_o=136, done 3 cycles later than the unstalled run.
- Mid-run clear: 8 pairs (5, 5), then carpma_rst_i=1 for 1 cycle, then 16 pairs (1, 1) -> after the clear edge sonuc_o=0 and adet_o=0. Final sonuc_o=16 with none of the earlier 25s leaked in.
- Excess operands: 20 pairs (2, 2) -> sonuc_o=64 and adet_o=16. Pairs 17–20 are ignored, and sonuc_o holds at 64 for 5 further cycles.
- Async reset: drop rst_ni between clock edges mid-run (sonuc_o=0x30) -> all outputs become 0 immediately without a clock edge. After release, a fresh 16×(1,1) run gives 16.
